// File: rtl/fetch_pc_gen_pkg.sv
// Core-wide fetch definitions: reset vector, instruction size, IF FSM states
// and the prediction record that travels down the pipeline with each branch.
package fetch_pc_gen_pkg;

    localparam logic [31:0] RESET_PC    = 32'h0000_0000;
    localparam logic [31:0] INSTR_BYTES = 32'd4;

    typedef enum logic [1:0] {
        S_RST    = 2'd0,
        S_RUN    = 2'd1,
        S_BUBBLE = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic        taken;
        logic [31:0] target;
    } pred_info_t;

    function automatic logic [31:0] seq_pc(input logic [31:0] pc);
        return pc + INSTR_BYTES;
    endfunction

endpackage

// File: rtl/fetch_pc_gen_if.sv
// Fetch-side bundle: MEM resolution inputs, stall/predictor inputs and the
// IF outputs. The master side is the PC generator itself.
interface fetch_pc_gen_if;

    logic        stall;
    logic        btb_taken;
    logic        mem_branch;
    logic        mem_pcsrc;
    logic [31:0] mem_pc;
    logic [31:0] mem_target;
    logic        mem_pred_taken;
    logic [31:0] mem_pred_target;
    logic [31:0] if_pc;
    logic        if_valid;
    logic        if_pred_taken;
    logic [31:0] if_pred_target;
    logic        flush;

    modport master (
        input  stall, btb_taken, mem_branch, mem_pcsrc, mem_pc, mem_target,
               mem_pred_taken, mem_pred_target,
        output if_pc, if_valid, if_pred_taken, if_pred_target, flush
    );

    modport slave (
        output stall, btb_taken, mem_branch, mem_pcsrc, mem_pc, mem_target,
               mem_pred_taken, mem_pred_target,
        input  if_pc, if_valid, if_pred_taken, if_pred_target, flush
    );

endinterface

// File: rtl/fetch_pc_gen_btb_target_table.sv
// Direct-mapped branch-target table: combinational lookup on the fetch PC,
// one registered write port fed by resolved taken branches.
module btb_target_table #(
    parameter int ENTRIES = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_lookup_pc,
    output logic        o_hit,
    output logic [31:0] o_target,
    input  logic        i_wr_en,
    input  logic [31:0] i_wr_pc,
    input  logic [31:0] i_wr_target
);
    import fetch_pc_gen_pkg::*;

    localparam int IDX   = $clog2(ENTRIES);
    localparam int TAG_W = 32 - IDX - 2;

    logic [ENTRIES-1:0]            r_valid;
    logic [ENTRIES-1:0][TAG_W-1:0] r_tag;
    logic [ENTRIES-1:0][31:0]      r_target;

    logic [IDX-1:0]   w_rd_idx;
    logic [TAG_W-1:0] w_rd_tag;
    logic [IDX-1:0]   w_wr_idx;
    logic [TAG_W-1:0] w_wr_tag;
    logic             w_unused;

    assign w_rd_idx = i_lookup_pc[IDX+1:2];
    assign w_rd_tag = i_lookup_pc[31:IDX+2];
    assign w_wr_idx = i_wr_pc[IDX+1:2];
    assign w_wr_tag = i_wr_pc[31:IDX+2];
    assign w_unused = ^{i_lookup_pc[1:0], i_wr_pc[1:0]};

    // Reads come straight off the registers, so a same-cycle write is only
    // visible to lookups from the next cycle on.
    assign o_hit    = r_valid[w_rd_idx] && (r_tag[w_rd_idx] == w_rd_tag);
    assign o_target = r_target[w_rd_idx];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= '0;
        end else if (i_wr_en) begin
            r_valid[w_wr_idx]  <= 1'b1;
            r_tag[w_wr_idx]    <= w_wr_tag;
            r_target[w_wr_idx] <= i_wr_target;
        end
    end

endmodule

// File: rtl/fetch_pc_gen.sv
// IF-stage next-PC generator: fetch PC register, target-table steering,
// MEM misprediction redirect/flush and the run/bubble fetch FSM.
module fetch_pc_gen #(
    parameter logic [31:0] RESET_PC = fetch_pc_gen_pkg::RESET_PC,
    parameter int          ENTRIES  = 16
) (
    input  logic              clock,
    input  logic              reset,
    fetch_pc_gen_if.master    bus
);
    import fetch_pc_gen_pkg::*;

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;
    logic [31:0]  r_pc;
    logic [31:0]  w_pc_nxt;
    logic [31:0]  w_redirect;
    logic         w_mispredict;
    logic         w_hit;
    logic [31:0]  w_tbl_target;
    logic         w_if_valid;
    pred_info_t   w_pred;

    btb_target_table #(
        .ENTRIES (ENTRIES)
    ) u_btb (
        .i_clk       (clock),
        .i_rst       (reset),
        .i_lookup_pc (r_pc),
        .o_hit       (w_hit),
        .o_target    (w_tbl_target),
        .i_wr_en     (bus.mem_branch & bus.mem_pcsrc),
        .i_wr_pc     (bus.mem_pc),
        .i_wr_target (bus.mem_target)
    );

    assign w_pred.taken  = bus.btb_taken & w_hit;
    assign w_pred.target = w_pred.taken ? w_tbl_target : 32'h0;

    assign w_mispredict = bus.mem_branch &
                          ((bus.mem_pcsrc != bus.mem_pred_taken) |
                           (bus.mem_pcsrc & bus.mem_pred_taken &
                            (bus.mem_pred_target != bus.mem_target)));

    assign w_redirect = bus.mem_pcsrc ? bus.mem_target : seq_pc(bus.mem_pc);

    // FSM: state register
    always_ff @(posedge clock) begin
        if (reset) r_state <= S_RST;
        else       r_state <= w_state_nxt;
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RST:    w_state_nxt = S_RUN;
            S_RUN:    w_state_nxt = w_mispredict ? S_BUBBLE : S_RUN;
            S_BUBBLE: w_state_nxt = w_mispredict ? S_BUBBLE : S_RUN;
            default:  w_state_nxt = S_RST;
        endcase
    end

    // FSM: outputs
    always_comb begin
        w_if_valid = 1'b0;
        case (r_state)
            S_RUN:   w_if_valid = ~w_mispredict;
            default: w_if_valid = 1'b0;
        endcase
    end

    // An invalid slot (S_RST/S_BUBBLE) holds the PC so the reset vector or
    // redirect target is the first address actually presented as valid.
    always_comb begin
        w_pc_nxt = seq_pc(r_pc);
        if (w_mispredict)                        w_pc_nxt = w_redirect;
        else if (bus.stall || r_state != S_RUN)  w_pc_nxt = r_pc;
        else if (w_pred.taken)                   w_pc_nxt = w_pred.target;
    end

    always_ff @(posedge clock) begin
        if (reset) r_pc <= RESET_PC;
        else       r_pc <= w_pc_nxt;
    end

    assign bus.if_pc          = r_pc;
    assign bus.if_valid       = w_if_valid;
    assign bus.if_pred_taken  = w_pred.taken;
    assign bus.if_pred_target = w_pred.target;
    assign bus.flush          = w_mispredict;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Scenario bench for fetch_pc_gen: expected post-edge PC/valid pairs are
// queued as stimulus is driven and popped after each clock edge.
module tb_fetch_pc_gen;

    typedef struct {
        logic [31:0] pc;
        logic        vld;
    } exp_t;

    logic clock;
    logic reset;
    int   total;
    int   bad;
    exp_t q[$];

    fetch_pc_gen_if ifc ();

    fetch_pc_gen dut (
        .clock (clock),
        .reset (reset),
        .bus   (ifc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: no finish by time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_mem();
        ifc.mem_branch      = 1'b0;
        ifc.mem_pcsrc       = 1'b0;
        ifc.mem_pc          = 32'h0;
        ifc.mem_target      = 32'h0;
        ifc.mem_pred_taken  = 1'b0;
        ifc.mem_pred_target = 32'h0;
    endtask

    task automatic expect_pc(input logic [31:0] pc, input logic vld);
        exp_t e;
        e.pc  = pc;
        e.vld = vld;
        q.push_back(e);
    endtask

    // Mispredict a not-taken branch at addr-4 so fetch lands on addr (valid).
    task automatic redirect(input logic [31:0] addr);
        ifc.mem_branch      = 1'b1;
        ifc.mem_pcsrc       = 1'b0;
        ifc.mem_pred_taken  = 1'b1;
        ifc.mem_pred_target = addr;
        ifc.mem_pc          = addr - 32'd4;
        tick();
        clear_mem();
        tick();
    endtask

    task automatic test_reset();
        exp_t e;
        reset = 1'b1;
        ifc.stall = 1'b0;
        ifc.btb_taken = 1'b0;
        clear_mem();
        repeat (3) tick();
        total++;
        if (ifc.if_pc !== 32'h0 || ifc.if_valid !== 1'b0 || ifc.flush !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: pc=%h vld=%b flush=%b want pc=0 vld=0 flush=0",
                     ifc.if_pc, ifc.if_valid, ifc.flush);
        end
        reset = 1'b0;
        #1;
        expect_pc(32'h0, 1'b0);
        expect_pc(32'h0, 1'b1);
        expect_pc(32'h4, 1'b1);
        expect_pc(32'h8, 1'b1);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            e = q.pop_front();
            total++;
            if (ifc.if_pc !== e.pc || ifc.if_valid !== e.vld) begin
                bad++;
                $display("FAIL reset_release[%0d]: pc=%h vld=%b want pc=%h vld=%b",
                         i, ifc.if_pc, ifc.if_valid, e.pc, e.vld);
            end
        end
    endtask

    task automatic test_learn();
        exp_t e;
        ifc.mem_branch = 1'b1;
        ifc.mem_pcsrc = 1'b1;
        ifc.mem_pred_taken = 1'b0;
        ifc.mem_pc = 32'h10;
        ifc.mem_target = 32'h80;
        #1;
        total++;
        if (ifc.flush !== 1'b1 || ifc.if_valid !== 1'b0) begin
            bad++;
            $display("FAIL learn_flush: flush=%b vld=%b want flush=1 vld=0", ifc.flush, ifc.if_valid);
        end
        expect_pc(32'h80, 1'b0);
        expect_pc(32'h80, 1'b1);
        for (int i = 0; i < 2; i++) begin
            tick();
            if (i == 0) clear_mem();
            #1;
            e = q.pop_front();
            total++;
            if (ifc.if_pc !== e.pc || ifc.if_valid !== e.vld || ifc.flush !== 1'b0) begin
                bad++;
                $display("FAIL learn_redirect[%0d]: pc=%h vld=%b flush=%b want pc=%h vld=%b flush=0",
                         i, ifc.if_pc, ifc.if_valid, ifc.flush, e.pc, e.vld);
            end
        end
    endtask

    task automatic test_predicted_hit();
        exp_t e;
        redirect(32'h10);
        ifc.btb_taken = 1'b1;
        #1;
        total++;
        if (ifc.if_pred_taken !== 1'b1 || ifc.if_pred_target !== 32'h80 || ifc.flush !== 1'b0) begin
            bad++;
            $display("FAIL pred_hit: taken=%b target=%h flush=%b want taken=1 target=00000080 flush=0",
                     ifc.if_pred_taken, ifc.if_pred_target, ifc.flush);
        end
        expect_pc(32'h80, 1'b1);
        tick();
        ifc.btb_taken = 1'b0;
        e = q.pop_front();
        total++;
        if (ifc.if_pc !== e.pc || ifc.if_valid !== e.vld) begin
            bad++;
            $display("FAIL pred_hit_next: pc=%h vld=%b want pc=%h vld=%b", ifc.if_pc, ifc.if_valid, e.pc, e.vld);
        end
    endtask

    task automatic test_wrong_pred();
        exp_t e;
        ifc.mem_branch = 1'b1;
        ifc.mem_pcsrc = 1'b0;
        ifc.mem_pred_taken = 1'b1;
        ifc.mem_pred_target = 32'h80;
        ifc.mem_pc = 32'h10;
        ifc.mem_target = 32'h80;
        #1;
        total++;
        if (ifc.flush !== 1'b1) begin
            bad++;
            $display("FAIL wrong_pred_flush: flush=%b want 1", ifc.flush);
        end
        expect_pc(32'h14, 1'b0);
        expect_pc(32'h14, 1'b1);
        for (int i = 0; i < 2; i++) begin
            tick();
            if (i == 0) clear_mem();
            e = q.pop_front();
            total++;
            if (ifc.if_pc !== e.pc || ifc.if_valid !== e.vld) begin
                bad++;
                $display("FAIL wrong_pred[%0d]: pc=%h vld=%b want pc=%h vld=%b",
                         i, ifc.if_pc, ifc.if_valid, e.pc, e.vld);
            end
        end
    endtask

    task automatic test_mismatch_stall();
        exp_t e;
        ifc.stall = 1'b1;
        ifc.mem_branch = 1'b1;
        ifc.mem_pcsrc = 1'b1;
        ifc.mem_pred_taken = 1'b1;
        ifc.mem_pred_target = 32'h80;
        ifc.mem_target = 32'hC0;
        ifc.mem_pc = 32'h10;
        #1;
        total++;
        if (ifc.flush !== 1'b1) begin
            bad++;
            $display("FAIL mismatch_flush: flush=%b want 1", ifc.flush);
        end
        expect_pc(32'hC0, 1'b0);
        expect_pc(32'hC0, 1'b1);
        expect_pc(32'hC0, 1'b1);
        expect_pc(32'hC4, 1'b1);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) ifc.stall = 1'b0;
            tick();
            if (i == 0) clear_mem();
            e = q.pop_front();
            total++;
            if (ifc.if_pc !== e.pc || ifc.if_valid !== e.vld) begin
                bad++;
                $display("FAIL mismatch_stall[%0d]: pc=%h vld=%b want pc=%h vld=%b",
                         i, ifc.if_pc, ifc.if_valid, e.pc, e.vld);
            end
        end
    endtask

    task automatic test_alias();
        exp_t e;
        ifc.mem_branch = 1'b1;
        ifc.mem_pcsrc = 1'b1;
        ifc.mem_pred_taken = 1'b1;
        ifc.mem_pred_target = 32'h100;
        ifc.mem_target = 32'h100;
        ifc.mem_pc = 32'h50;
        #1;
        total++;
        if (ifc.flush !== 1'b0) begin
            bad++;
            $display("FAIL alias_correct_pred: flush=%b want 0", ifc.flush);
        end
        expect_pc(32'hC8, 1'b1);
        tick();
        clear_mem();
        e = q.pop_front();
        total++;
        if (ifc.if_pc !== e.pc || ifc.if_valid !== e.vld) begin
            bad++;
            $display("FAIL alias_seq: pc=%h vld=%b want pc=%h vld=%b", ifc.if_pc, ifc.if_valid, e.pc, e.vld);
        end
        redirect(32'h10);
        ifc.btb_taken = 1'b1;
        #1;
        total++;
        if (ifc.if_pred_taken !== 1'b0 || ifc.if_pred_target !== 32'h0) begin
            bad++;
            $display("FAIL alias_tag_miss: taken=%b target=%h want taken=0 target=0",
                     ifc.if_pred_taken, ifc.if_pred_target);
        end
        expect_pc(32'h14, 1'b1);
        tick();
        ifc.btb_taken = 1'b0;
        e = q.pop_front();
        total++;
        if (ifc.if_pc !== e.pc || ifc.if_valid !== e.vld) begin
            bad++;
            $display("FAIL alias_next: pc=%h vld=%b want pc=%h vld=%b", ifc.if_pc, ifc.if_valid, e.pc, e.vld);
        end
    endtask

    task automatic test_same_cycle();
        exp_t e;
        redirect(32'h10);
        ifc.btb_taken = 1'b1;
        ifc.mem_branch = 1'b1;
        ifc.mem_pcsrc = 1'b1;
        ifc.mem_pred_taken = 1'b1;
        ifc.mem_pred_target = 32'h200;
        ifc.mem_target = 32'h200;
        ifc.mem_pc = 32'h10;
        #1;
        total++;
        if (ifc.if_pred_taken !== 1'b0 || ifc.flush !== 1'b0) begin
            bad++;
            $display("FAIL same_cycle_old: taken=%b flush=%b want taken=0 flush=0",
                     ifc.if_pred_taken, ifc.flush);
        end
        expect_pc(32'h14, 1'b1);
        tick();
        clear_mem();
        e = q.pop_front();
        total++;
        if (ifc.if_pc !== e.pc || ifc.if_valid !== e.vld) begin
            bad++;
            $display("FAIL same_cycle_next: pc=%h vld=%b want pc=%h vld=%b", ifc.if_pc, ifc.if_valid, e.pc, e.vld);
        end
        redirect(32'h10);
        #1;
        total++;
        if (ifc.if_pred_taken !== 1'b1 || ifc.if_pred_target !== 32'h200) begin
            bad++;
            $display("FAIL same_cycle_new: taken=%b target=%h want taken=1 target=00000200",
                     ifc.if_pred_taken, ifc.if_pred_target);
        end
        expect_pc(32'h200, 1'b1);
        tick();
        ifc.btb_taken = 1'b0;
        e = q.pop_front();
        total++;
        if (ifc.if_pc !== e.pc || ifc.if_valid !== e.vld) begin
            bad++;
            $display("FAIL same_cycle_jump: pc=%h vld=%b want pc=%h vld=%b", ifc.if_pc, ifc.if_valid, e.pc, e.vld);
        end
    endtask

    task automatic test_no_branch();
        exp_t e;
        ifc.mem_branch = 1'b0;
        ifc.mem_pcsrc = 1'b1;
        ifc.mem_pred_taken = 1'b0;
        ifc.mem_target = 32'h300;
        ifc.mem_pc = 32'h200;
        #1;
        total++;
        if (ifc.flush !== 1'b0 || ifc.if_valid !== 1'b1) begin
            bad++;
            $display("FAIL no_branch_flush: flush=%b vld=%b want flush=0 vld=1", ifc.flush, ifc.if_valid);
        end
        expect_pc(32'h204, 1'b1);
        tick();
        clear_mem();
        e = q.pop_front();
        total++;
        if (ifc.if_pc !== e.pc || ifc.if_valid !== e.vld) begin
            bad++;
            $display("FAIL no_branch_seq: pc=%h vld=%b want pc=%h vld=%b", ifc.if_pc, ifc.if_valid, e.pc, e.vld);
        end
        redirect(32'h200);
        ifc.btb_taken = 1'b1;
        #1;
        total++;
        if (ifc.if_pred_taken !== 1'b0) begin
            bad++;
            $display("FAIL no_branch_nowrite: taken=%b want 0", ifc.if_pred_taken);
        end
        ifc.btb_taken = 1'b0;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        reset = 1'b1;
        ifc.mem_branch = 1'b1;
        ifc.mem_pcsrc = 1'b1;
        ifc.mem_pred_taken = 1'b0;
        ifc.mem_target = 32'h400;
        ifc.mem_pc = 32'h8;
        expect_pc(32'h0, 1'b0);
        tick();
        clear_mem();
        #1;
        e = q.pop_front();
        total++;
        if (ifc.if_pc !== e.pc || ifc.if_valid !== e.vld || ifc.flush !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid: pc=%h vld=%b flush=%b want pc=%h vld=%b flush=0",
                     ifc.if_pc, ifc.if_valid, ifc.flush, e.pc, e.vld);
        end
        reset = 1'b0;
        tick();
        redirect(32'h10);
        ifc.btb_taken = 1'b1;
        #1;
        total++;
        if (ifc.if_pc !== 32'h10 || ifc.if_pred_taken !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_table_clear: pc=%h taken=%b want pc=00000010 taken=0",
                     ifc.if_pc, ifc.if_pred_taken);
        end
        ifc.btb_taken = 1'b0;
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_learn();
        test_predicted_hit();
        test_wrong_pred();
        test_mismatch_stall();
        test_alias();
        test_same_cycle();
        test_no_branch();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_pc_gen.md
Name: fetch_pc_gen

Overview:
- IF-stage next-PC generator. Owns the fetch PC register and a direct-mapped branch-target table.
- Combines the 2-bit direction predictor's taken bit (btb_taken, looked up with if_pc) with a target hit to steer fetch.
- Resolves mispredictions reported from MEM: redirects the PC and issues a flush.
- Drives the predictor's pc input; its MEM-side update ports share sources with the predictor's mem_pc/pcsrc/branch.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset.
- ENTRIES, 16, target-table depth (power of 2; index = pc[IDX+1:2], IDX = log2(ENTRIES)).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- stall  in  1  hazard stall; hold if_pc
- btb_taken  in  1  predictor direction for if_pc
- mem_branch  in  1  MEM-stage instruction is a conditional branch
- mem_pcsrc  in  1  MEM-stage branch actually taken
- mem_pc  in  32  MEM-stage branch PC
- mem_target  in  32  MEM-stage resolved taken target
- mem_pred_taken  in  1  prediction carried down the pipeline with this branch
- mem_pred_target  in  32  predicted target carried down the pipeline
- if_pc  out  32  current fetch PC (also drives predictor pc)
- if_valid  out  1  fetch slot valid
- if_pred_taken  out  1  prediction applied to if_pc
- if_pred_target  out  32  target used when if_pred_taken=1, else 0
- flush  out  1  kill IF/ID/EX younger instructions

Behaviour:
- Table entry = valid, tag pc[31:IDX+2], target[31:0]. Lookup is combinational on if_pc; hit = valid & tag match.
- if_pred_taken = btb_taken & hit. if_pred_target = hit ? target : 0 when taken, else 0.
- mispredict (combinational) = mem_branch & ((mem_pcsrc != mem_pred_taken) | (mem_pcsrc & mem_pred_taken & mem_pred_target != mem_target)).
- flush = mispredict, same cycle; it is not registered.
- Redirect address = mem_pcsrc ? mem_target : mem_pc + 4. Adders wrap modulo 2^32.
- Next-PC priority, registered on the rising clock edge:
  - reset -> RESET_PC
  - mispredict -> redirect address (overrides stall)
  - stall -> hold
  - if_pred_taken -> if_pred_target
  - otherwise -> if_pc + 4
- Table write: on mem_branch & mem_pcsrc, entry[mem_pc index] <= {1, mem_pc tag, mem_target}. Not-taken branches leave the entry unchanged.
- Same-cycle write and lookup to the same index: the lookup sees the old contents.
- FSM with states S_RST, S_RUN, S_BUBBLE:
  - reset -> S_RST, if_valid=0.
  - S_RST -> S_RUN on the first non-reset cycle.
  - S_RUN + mispredict -> S_BUBBLE. if_valid=1 in S_RUN unless flush is asserted.
  - S_BUBBLE -> S_RUN next cycle. if_valid=0 in S_BUBBLE, so the redirected PC is presented one cycle later.
  - A mispredict in S_BUBBLE is still honoured: redirect and remain in S_BUBBLE.
- Reset values: if_pc=RESET_PC, if_valid=0, flush=0, all valid bits=0, state=S_RST.
- Reset asserted mid-operation clears all state next edge and overrides all other inputs.
- If mem_branch=0, mispredict=0 regardless of the other mem_* inputs.

Decomposition:
- Shared package (core-wide, reused by the predictor and the pipeline registers): RESET_PC, the INSTR_BYTES=4 constant, the FSM state enum, and a pred_info struct {taken, target} carried down the pipeline.
- One natural sub-module: btb_target_table (storage, lookup, write port). The FSM and next-PC mux stay in fetch_pc_gen.

Test Plan:
- Reset release: reset held 3 cycles then dropped, stall=0, no branches -> if_valid=0 first cycle, then if_pc=0x0, 0x4, 0x8 with if_valid=1.
- Learn taken branch: mem_branch=1, mem_pcsrc=1, mem_pred_taken=0, mem_pc=0x10, mem_target=0x80 -> flush=1 that cycle; next if_pc=0x80; one bubble cycle (if_valid=0); entry 4 valid with target 0x80.
- Predicted hit: if_pc=0x10, btb_taken=1 after the learn step -> if_pred_taken=1, if_pred_target=0x80; next if_pc=0x80 with no flush.
- Wrong prediction: MEM reports mem_pc=0x10, mem_pred_taken=1, mem_pcsrc=0 -> flush=1, next if_pc=0x14.
- Target mismatch and stall: pred taken to 0x80, actual taken to 0xC0, with stall=1 the same cycle -> redirect wins, next if_pc=0xC0.
- Aliasing and collisions:
  - mem_pc=0x50 shares index 4 with 0x10 and is written with target 0x100. A later lookup at 0x10 misses on tag, so if_pred_taken=0 even with btb_taken=1.
  - A write to index 4 in the same cycle as a lookup at 0x10 -> the lookup returns the old entry.
